am_lock_engine: RTL

AM_LOCK_ENGINE -- requirements
Module: am_lock_engine

---
 rtl/am_lock_engine.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/am_lock_engine.sv
// Alignment-marker lock engine: finds the per-lane AM, tracks its period,
// checks BIP3 across each period and optionally replaces locked AMs with idles.
module am_lock_engine #(
  parameter int NB_CODED_BLOCK   = 66,
  parameter int N_ALIGNER        = 20,
  parameter int NB_LANE_ID       = $clog2(N_ALIGNER),
  parameter int AM_PERIOD        = 16384,
  parameter int NB_ERROR_COUNTER = 32,
  parameter int NB_THR           = 5
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_valid,
  input  logic                        i_block_lock,
  input  logic [NB_CODED_BLOCK-1:0]   i_data,
  input  logic [N_ALIGNER*48-1:0]     i_am_table,
  input  logic [NB_THR-1:0]           i_valid_am_thr,
  input  logic [NB_THR-1:0]           i_invalid_am_thr,
  input  logic                        i_am_replace,
  output logic                        o_valid,
  output logic [NB_CODED_BLOCK-1:0]   o_data,
  output logic [NB_LANE_ID-1:0]       o_lane_id,
  output logic                        o_am_lock,
  output logic                        o_start_of_lane,
  output logic                        o_resync,
  output logic                        o_bip_error,
  output logic [NB_ERROR_COUNTER-1:0] o_error_counter
);

  // i_valid && i_enable qualifies each input block; there is no backpressure,
  // and o_valid qualifies o_data exactly one clock after the source block.

  localparam int NB_CNT = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(AM_PERIOD - 1);
  localparam logic [NB_CODED_BLOCK-1:0] IDLE_BLOCK = NB_CODED_BLOCK'({2'b10, 8'h1E, 56'h0});

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                      state, state_n;
  logic [NB_CNT-1:0]           cnt, cnt_n;
  logic [NB_LANE_ID-1:0]       lane, lane_n;
  logic [NB_THR-1:0]           vcnt, vcnt_n, icnt, icnt_n;
  logic [NB_THR-1:0]           vcnt_inc, icnt_inc, vthr_eff, ithr_eff;
  logic [7:0]                  acc, acc_n, blk_bip;
  logic [NB_ERROR_COUNTER-1:0] err_cnt, err_n;
  logic                        sol_n, resync_n, bip_err_n, replace;
  logic                        adv, slot0, match_any, match_lane;
  logic [NB_LANE_ID-1:0]       match_idx;

  function automatic logic [7:0] bip_contrib(input logic [NB_CODED_BLOCK-1:0] d);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 64; j++) begin
      b[j[2:0]] = b[j[2:0]] ^ d[j];
    end
    b[3] = b[3] ^ d[64];
    b[4] = b[4] ^ d[65];
    return b;
  endfunction

  assign adv      = i_valid & i_enable;
  assign slot0    = (cnt == '0);
  assign blk_bip  = bip_contrib(i_data);
  assign vcnt_inc = vcnt + NB_THR'(1);
  assign icnt_inc = icnt + NB_THR'(1);
  assign vthr_eff = (i_valid_am_thr == '0) ? NB_THR'(1) : i_valid_am_thr;
  assign ithr_eff = (i_invalid_am_thr == '0) ? NB_THR'(1) : i_invalid_am_thr;

  // Descending scan so the lowest matching entry overrides the others.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int k = N_ALIGNER - 1; k >= 0; k--) begin
      if (i_data[65:64] == 2'b10 &&
          {i_data[63:40], i_data[31:8]} == i_am_table[48*k +: 48]) begin
        match_any = 1'b1;
        match_idx = NB_LANE_ID'(k);
      end
    end
  end

  assign match_lane = match_any && (match_idx == lane);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lane_n    = lane;
    vcnt_n    = vcnt;
    icnt_n    = icnt;
    acc_n     = acc;
    err_n     = err_cnt;
    sol_n     = 1'b0;
    resync_n  = 1'b0;
    bip_err_n = 1'b0;
    replace   = 1'b0;
    if (!i_block_lock) begin
      state_n  = ST_SEARCH;
      cnt_n    = '0;
      lane_n   = '0;
      vcnt_n   = '0;
      icnt_n   = '0;
      resync_n = (state != ST_SEARCH);
      if (adv) acc_n = acc ^ blk_bip;
    end else if (adv) begin
      acc_n = acc ^ blk_bip;
      cnt_n = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      case (state)
        ST_SEARCH: begin
          cnt_n = '0;
          if (match_any) begin
            state_n = ST_CONFIRM;
            lane_n  = match_idx;
            cnt_n   = NB_CNT'(1);
            vcnt_n  = NB_THR'(1);
            acc_n   = blk_bip;
          end
        end
        ST_CONFIRM: begin
          if (slot0) begin
            acc_n = blk_bip;
            if (match_lane) begin
              vcnt_n = vcnt_inc;
              if (vcnt_inc >= vthr_eff) begin
                state_n = ST_LOCKED;
                icnt_n  = '0;
              end
            end else begin
              state_n  = ST_SEARCH;
              resync_n = 1'b1;
              lane_n   = '0;
              vcnt_n   = '0;
              cnt_n    = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (slot0) begin
            // The accumulator restarts from the AM itself for the next period.
            acc_n = blk_bip;
            if (match_lane) begin
              icnt_n  = '0;
              sol_n   = 1'b1;
              replace = i_am_replace;
              if (acc != i_data[39:32]) begin
                bip_err_n = 1'b1;
                if (err_cnt != '1) err_n = err_cnt + 1'b1;
              end
            end else begin
              icnt_n = icnt_inc;
              if (icnt_inc >= ithr_eff) begin
                state_n  = ST_SEARCH;
                resync_n = 1'b1;
                lane_n   = '0;
                vcnt_n   = '0;
                icnt_n   = '0;
                cnt_n    = '0;
              end
            end
          end
        end
        default: begin
          state_n = ST_SEARCH;
          lane_n  = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state           <= ST_SEARCH;
      cnt             <= '0;
      lane            <= '0;
      vcnt            <= '0;
      icnt            <= '0;
      acc             <= '0;
      err_cnt         <= '0;
      o_valid         <= 1'b0;
      o_data          <= '0;
      o_start_of_lane <= 1'b0;
      o_resync        <= 1'b0;
      o_bip_error     <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      lane            <= lane_n;
      vcnt            <= vcnt_n;
      icnt            <= icnt_n;
      acc             <= acc_n;
      err_cnt         <= err_n;
      o_valid         <= adv;
      o_start_of_lane <= sol_n;
      o_resync        <= resync_n;
      o_bip_error     <= bip_err_n;
      if (adv) o_data <= replace ? IDLE_BLOCK : i_data;
    end
  end

  assign o_am_lock       = (state == ST_LOCKED);
  assign o_lane_id       = lane;
  assign o_error_counter = err_cnt;

endmodule
